ysyx_23060025_icache_axi_rd: RTL and testbench
==============================================

YSYX_23060025_ICACHE_AXI_RD -- requirements
Module: ysyx_23060025_icache_axi_rd

Interface
REQ-001 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-002 SHALL have parameter AXI_ID, default 0, constant ID driven on arid.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low.
- in_paddr  in  32  burst start address from icache.
- in_psel  in  1  level request from icache; held until after last beat.
- in_arlen  in  8  beats minus one.
- in_arsize  in  3  beat size.
- out_rvalid  out  1  beat valid to icache.
- out_rlast  out  1  last beat to icache.
- out_rdata  out  32  beat data to icache.
- out_err  out  1  sticky error for the current request.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  32  AXI AR address.
- arid  out  ID_W  AXI AR ID.
- arlen  out  8  AXI AR length.
- arsize  out  3  AXI AR size.
- arburst  out  2  AXI AR burst type.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- rdata  in  32  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last.
- rid  in  ID_W  AXI R ID.

Function
REQ-004 SHALL implement FSM states IDLE, ADDR, DATA, WAIT_REL.
REQ-005 IDLE->ADDR SHALL occur when in_psel==1; in_paddr/in_arlen/in_arsize SHALL be latched that cycle.
REQ-006 In ADDR, arvalid SHALL be 1 and araddr/arlen/arsize SHALL carry the latched values, stable until the arready handshake.
REQ-007 arburst SHALL be INCR (2'b01) and arid SHALL equal AXI_ID in all cycles.
REQ-008 ADDR->DATA SHALL occur on the cycle arvalid&arready; arvalid SHALL be 0 the following cycle.
REQ-009 rready SHALL be 1 exactly while in DATA.
REQ-010 Per R handshake (rvalid&rready), out_rvalid SHALL pulse high for one cycle, registered, one cycle after the handshake, with out_rdata=rdata and out_rlast=rlast.
REQ-011 An 8-bit beat counter SHALL clear on ADDR entry and increment per R handshake.
REQ-012 DATA->WAIT_REL SHALL occur on the handshake with rlast==1; the burst SHALL end on AXI rlast regardless of the count.
REQ-013 WAIT_REL->IDLE SHALL occur when in_psel==0; no second AR SHALL be issued while in_psel stays high after completion.
REQ-014 out_err SHALL set on any of:
- rresp!=2'b00 on a handshake;
- rid!=AXI_ID on a handshake;
- rlast on beat index != latched arlen;
- beat index > arlen without rlast.
REQ-015 out_err SHALL clear on IDLE->ADDR.
REQ-016 rdata/rlast SHALL be ignored outside DATA; rvalid with rready==0 SHALL cause no action.
REQ-017 An in_psel drop during ADDR or DATA SHALL NOT abort the burst (AXI protocol); the FSM SHALL finish and return to IDLE directly.
REQ-018 Latency SHALL be 1 cycle from psel to arvalid and 1 cycle from R handshake to out_rvalid; back-to-back beats SHALL sustain 1 beat/cycle.

Reset
REQ-019 With reset==0 at a clock edge, the state SHALL become IDLE and arvalid, rready, out_rvalid, out_rlast, out_err and the beat counter SHALL become 0; out_rdata SHALL become 0.
REQ-020 Reset mid-burst SHALL abandon the burst; the interconnect SHALL be reset in the same system reset (not recovered by this block).
REQ-021 The first request after reset release SHALL be accepted with no extra idle cycle.

Structure
REQ-022 The constants AXI_BURST_INCR, AXI_RESP_OKAY and AXI_ADDR_SIZE_4 SHALL reside in the shared define file, together with the state encodings.
REQ-023 The block SHALL be a single module with no sub-module; the R-beat output register is inline.

Verification
REQ-024 Directed scenario: psel, paddr=0x8000_0010, arlen=1, size=2, arready=1 -> arvalid next cycle with araddr=0x8000_0010; two beats 0x11111111 and 0x22222222 (rlast on 2nd) -> out_rvalid 2 cycles, out_rlast on 2nd, out_err=0.
REQ-025 Directed scenario: arready held low for 5 cycles -> arvalid/araddr stable for 6 cycles, rready=0 throughout.
REQ-026 Directed scenario: rresp=2'b10 on beat 0 -> out_err=1 through WAIT_REL; cleared on next request.
REQ-027 Directed scenario: arlen=1 but rlast on beat 0 -> out_err=1, FSM to WAIT_REL, one out_rvalid with out_rlast=1.
REQ-028 Directed scenario: psel held 3 cycles after rlast -> exactly one AR total; IDLE after psel falls; new psel -> second AR.
REQ-029 Directed scenario: reset==0 asserted mid-DATA -> next cycle all outputs 0, state IDLE; a subsequent request behaves per REQ-024.

Source files
------------

// File: rtl/ysyx_23060025_icache_axi_rd_pkg.sv
// rtl/ysyx_23060025_icache_axi_rd_pkg.sv - shared AXI constants and read-FSM state encodings
package ysyx_23060025_icache_axi_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADDR     = 2'd1,
        ST_DATA     = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [2:0] AXI_ADDR_SIZE_4 = 3'b010;

endpackage

// File: rtl/ysyx_23060025_icache_axi_rd.sv
// rtl/ysyx_23060025_icache_axi_rd.sv - icache refill burst reader on an AXI read channel
module ysyx_23060025_icache_axi_rd
    import ysyx_23060025_icache_axi_rd_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     in_paddr,
    input  logic            in_psel,
    input  logic [7:0]      in_arlen,
    input  logic [2:0]      in_arsize,
    output logic            out_rvalid,
    output logic            out_rlast,
    output logic [31:0]     out_rdata,
    output logic            out_err,
    output logic            arvalid,
    input  logic            arready,
    output logic [31:0]     araddr,
    output logic [ID_W-1:0] arid,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    input  logic            rvalid,
    output logic            rready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic [ID_W-1:0] rid
);

    localparam logic [ID_W-1:0] ID_VAL = ID_W'(AXI_ID);

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [7:0]  beat_cnt;
    logic        r_hs;
    logic        beat_err;
    logic        start;

    assign r_hs  = (state == ST_DATA) && rvalid;
    assign start = (state == ST_IDLE) && in_psel;

    // beat_cnt is the index of the beat being accepted, before increment
    assign beat_err = (rresp != AXI_RESP_OKAY) || (rid != ID_VAL)
                    || (rlast && (beat_cnt != len_q))
                    || (!rlast && (beat_cnt > len_q));

    assign arvalid = (state == ST_ADDR);
    assign rready  = (state == ST_DATA);
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = AXI_BURST_INCR;
    assign arid    = ID_VAL;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (in_psel) state_next = ST_ADDR;
            ST_ADDR:     if (arready) state_next = ST_DATA;
            // a requester that already let go gets no release phase
            ST_DATA:     if (r_hs && rlast) state_next = in_psel ? ST_WAIT_REL : ST_IDLE;
            ST_WAIT_REL: if (!in_psel) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            beat_cnt   <= '0;
            out_rvalid <= 1'b0;
            out_rlast  <= 1'b0;
            out_rdata  <= '0;
            out_err    <= 1'b0;
        end else begin
            state      <= state_next;
            out_rvalid <= r_hs;
            out_rlast  <= r_hs && rlast;
            if (start) begin
                addr_q   <= in_paddr;
                len_q    <= in_arlen;
                size_q   <= in_arsize;
                beat_cnt <= '0;
                out_err  <= 1'b0;
            end
            if (r_hs) begin
                out_rdata <= rdata;
                beat_cnt  <= beat_cnt + 8'd1;
                if (beat_err) out_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_icache_axi_rd.sv
// tb/tb_ysyx_23060025_icache_axi_rd.sv - scoreboard bench for the icache AXI burst reader
module tb_ysyx_23060025_icache_axi_rd;

    localparam int ID_W   = 4;
    localparam int AXI_ID = 5;

    logic            clock;
    logic            reset;
    logic [31:0]     in_paddr;
    logic            in_psel;
    logic [7:0]      in_arlen;
    logic [2:0]      in_arsize;
    logic            out_rvalid;
    logic            out_rlast;
    logic [31:0]     out_rdata;
    logic            out_err;
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;

    ysyx_23060025_icache_axi_rd #(.ID_W(ID_W), .AXI_ID(AXI_ID)) dut (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_arlen(in_arlen), .in_arsize(in_arsize),
        .out_rvalid(out_rvalid), .out_rlast(out_rlast), .out_rdata(out_rdata), .out_err(out_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; } ar_t;

    beat_t beat_q[$];
    ar_t   ar_q[$];
    beat_t mon_b;
    ar_t   mon_a;
    int    passed = 0;
    int    total  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // monitor: samples between active edges, pops expectations on every handshake/output beat
    always @(negedge clock) begin
        if (reset) begin
            if (out_rvalid) begin
                if (beat_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: out_rvalid=1 required 0");
                end else begin
                    mon_b = beat_q.pop_front();
                    check("beat_data", out_rdata, mon_b.data);
                    check("beat_last", out_rlast, mon_b.last);
                end
            end
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_ar: ar handshake with no request outstanding");
                end else begin
                    mon_a = ar_q.pop_front();
                    check("araddr", araddr, mon_a.addr);
                    check("arlen", arlen, mon_a.len);
                    check("arsize", arsize, mon_a.size);
                    check("arid", arid, AXI_ID);
                    check("arburst", arburst, 2'b01);
                end
            end
        end
    end

    // mode: 0 normal, 1 early rlast, 2 late rlast, 3 bad rresp, 4 bad rid
    task automatic do_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input int mode, input int ar_delay, input int hold,
                            input bit drop, input bit directed);
        int          last_i;
        int          bad_i;
        int          n;
        int          g;
        logic        exp_err;
        logic [31:0] d;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        lst;
        last_i = len;
        if (mode == 1 && len > 0) last_i = $urandom_range(len - 1, 0);
        if (mode == 2) last_i = len + 1 + $urandom_range(1, 0);
        bad_i = directed ? 0 : $urandom_range(last_i, 0);
        ar_q.push_back('{addr, 8'(len), size});
        in_psel = 1'b1; in_paddr = addr; in_arlen = 8'(len); in_arsize = size; arready = 1'b0;
        tick();
        check("ar_latency", arvalid, 1'b1);
        check("err_cleared", out_err, 1'b0);
        n = 0;
        while (!arvalid && n < 8) begin tick(); n++; end
        if (!arvalid) begin
            total++;
            $display("FAIL ar_timeout: arvalid=0 required 1");
            in_psel = 1'b0; ar_q.delete();
            tick();
            return;
        end
        in_paddr = $urandom; in_arlen = 8'($urandom); in_arsize = 3'($urandom);
        for (int c = 0; c < ar_delay; c++) begin
            rvalid = 1'($urandom); rlast = 1'($urandom); rdata = $urandom;
            tick();
            check("ar_hold_valid", arvalid, 1'b1);
            check("ar_hold_addr", araddr, addr);
            check("ar_hold_rready", rready, 1'b0);
        end
        rvalid = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;
        check("arvalid_after_hs", arvalid, 1'b0);
        check("rready_in_data", rready, 1'b1);
        if (drop) in_psel = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i <= last_i; i++) begin
            g = directed ? 0 : (($urandom_range(3, 0) == 0) ? $urandom_range(2, 1) : 0);
            for (int k = 0; k < g; k++) begin
                rvalid = 1'b0;
                tick();
                check("rready_gap", rready, 1'b1);
            end
            d    = directed ? 32'h11111111 * (i + 1) : $urandom;
            resp = (mode == 3 && i == bad_i) ? 2'b10 : 2'b00;
            id   = (mode == 4 && i == bad_i) ? (4'(AXI_ID) ^ 4'($urandom_range(15, 1))) : 4'(AXI_ID);
            lst  = (i == last_i);
            if (resp != 2'b00 || id != 4'(AXI_ID) || (lst && i != len) || (!lst && i > len))
                exp_err = 1'b1;
            beat_q.push_back('{d, lst});
            rvalid = 1'b1; rdata = d; rresp = resp; rid = id; rlast = lst;
            tick();
        end
        rvalid = 1'b0; rlast = 1'($urandom); rdata = $urandom;
        check("rready_done", rready, 1'b0);
        check("err_final", out_err, exp_err);
        if (!drop) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                check("no_second_ar", arvalid, 1'b0);
                check("err_hold", out_err, exp_err);
            end
            in_psel = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset = 1'b0; in_psel = 1'b0; in_paddr = '0; in_arlen = '0; in_arsize = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        repeat (3) tick();
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_out_rvalid", out_rvalid, 1'b0);
        check("rst_out_rlast", out_rlast, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_out_rdata", out_rdata, 32'h0);
        reset = 1'b1;

        do_burst(32'h8000_0010, 1, 3'd2, 0, 0, 0, 1'b0, 1'b1);
        do_burst($urandom, 2, 3'd2, 0, 5, 0, 1'b0, 1'b0);
        do_burst($urandom, 1, 3'd2, 3, 0, 2, 1'b0, 1'b1);
        do_burst($urandom, 1, 3'd2, 1, 0, 1, 1'b0, 1'b0);
        do_burst($urandom, 2, 3'd2, 0, 1, 3, 1'b0, 1'b0);
        do_burst($urandom, 3, 3'd2, 0, 0, 0, 1'b1, 1'b0);
        do_burst($urandom, 0, 3'd2, 2, 0, 1, 1'b0, 1'b0);

        // reset in the middle of a data phase
        ar_q.push_back('{32'h1234_5670, 8'd3, 3'd2});
        in_psel = 1'b1; in_paddr = 32'h1234_5670; in_arlen = 8'd3; in_arsize = 3'd2;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            beat_q.push_back('{32'hA5A5_0000 + i, 1'b0});
            rvalid = 1'b1; rdata = 32'hA5A5_0000 + i; rresp = 2'b00; rid = 4'(AXI_ID); rlast = 1'b0;
            tick();
        end
        rvalid = 1'b0;
        tick();
        reset = 1'b0; in_psel = 1'b0;
        tick();
        check("mid_rst_arvalid", arvalid, 1'b0);
        check("mid_rst_rready", rready, 1'b0);
        check("mid_rst_out_rvalid", out_rvalid, 1'b0);
        check("mid_rst_out_rlast", out_rlast, 1'b0);
        check("mid_rst_out_err", out_err, 1'b0);
        check("mid_rst_out_rdata", out_rdata, 32'h0);
        reset = 1'b1;
        do_burst(32'h8000_0010, 1, 3'd2, 0, 0, 0, 1'b0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            do_burst($urandom, $urandom_range(15, 0), 3'($urandom), $urandom_range(4, 0),
                     $urandom_range(3, 0), $urandom_range(2, 0),
                     ($urandom_range(3, 0) == 0), 1'b0);
        end

        repeat (3) tick();
        check("beat_q_drained", beat_q.size(), 0);
        check("ar_q_drained", ar_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
